// File: rtl/friscv_apb_router_pkg.sv
// rtl/friscv_apb_router_pkg.sv - shared types and helpers for the APB router
package friscv_apb_router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } apb_rt_state_t;

    // Width of a slave index; a single-slave router still needs one bit
    function automatic int idx_width(input int nb_slv);
        return (nb_slv > 1) ? $clog2(nb_slv) : 1;
    endfunction

endpackage

// File: rtl/friscv_apb_router_decode.sv
// rtl/friscv_apb_router_decode.sv - address to slave index decode, lowest index wins
module friscv_apb_router_decode
    import friscv_apb_router_pkg::*;
#(
    parameter int                      ADDRW    = 16,
    parameter int                      NB_SLV   = 4,
    parameter int                      IDXW     = idx_width(NB_SLV),
    parameter logic [NB_SLV*ADDRW-1:0] SLV_ADDR = '0,
    parameter logic [NB_SLV*ADDRW-1:0] SLV_SIZE = '0
)(
    input  logic [ADDRW-1:0] i_addr,
    output logic             o_hit,
    output logic [IDXW-1:0]  o_index
);

    logic [NB_SLV-1:0] w_hit;

    // Ranges are compared one bit wider so base+size never wraps to a small limit
    for (genvar i = 0; i < NB_SLV; i++) begin : g_range
        localparam logic [ADDRW:0] BASE  = {1'b0, SLV_ADDR[i*ADDRW +: ADDRW]};
        localparam logic [ADDRW:0] LIMIT = BASE + {1'b0, SLV_SIZE[i*ADDRW +: ADDRW]};
        assign w_hit[i] = ({1'b0, i_addr} >= BASE) && ({1'b0, i_addr} < LIMIT);
    end

    // Scan from the top down so the lowest matching index overrides the others
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_hit   = 1'b1;
                o_index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/friscv_apb_router.sv
// rtl/friscv_apb_router.sv - APB-lite router, one master to NB_SLV slaves with decode error and timeout
module friscv_apb_router
    import friscv_apb_router_pkg::*;
#(
    parameter int                      ADDRW    = 16,
    parameter int                      XLEN     = 32,
    parameter int                      NB_SLV   = 4,
    parameter logic [NB_SLV*ADDRW-1:0] SLV_ADDR = {16'h0300, 16'h0200, 16'h0100, 16'h0000},
    parameter logic [NB_SLV*ADDRW-1:0] SLV_SIZE = {16'h0100, 16'h0100, 16'h0100, 16'h0100},
    parameter int                      TIMEOUT  = 255
)(
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       srst,
    input  logic                       mst_en,
    input  logic                       mst_wr,
    input  logic [ADDRW-1:0]           mst_addr,
    input  logic [XLEN-1:0]            mst_wdata,
    input  logic [XLEN/8-1:0]          mst_strb,
    output logic [XLEN-1:0]            mst_rdata,
    output logic                       mst_ready,
    output logic                       mst_err,
    output logic [NB_SLV-1:0]          slv_en,
    output logic [NB_SLV-1:0]          slv_wr,
    output logic [NB_SLV*ADDRW-1:0]    slv_addr,
    output logic [NB_SLV*XLEN-1:0]     slv_wdata,
    output logic [NB_SLV*XLEN/8-1:0]   slv_strb,
    input  logic [NB_SLV*XLEN-1:0]     slv_rdata,
    input  logic [NB_SLV-1:0]          slv_ready
);

    localparam int IDXW  = idx_width(NB_SLV);
    localparam int STRBW = XLEN / 8;
    localparam int TMRW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMRW-1:0] TMR_LAST = TMRW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_rt_state_t    r_state;
    logic             r_rearm;
    logic [IDXW-1:0]  r_sel;
    logic [TMRW-1:0]  r_timer;
    logic             r_mst_ready;
    logic             r_mst_err;
    logic [XLEN-1:0]  r_mst_rdata;

    logic             w_hit;
    logic [IDXW-1:0]  w_idx;
    logic             w_accept;
    logic             w_start;
    logic             w_derr;
    logic             w_timeout;
    logic             w_sel_ready;
    logic [XLEN-1:0]  w_sel_rdata;
    logic             w_acc_done;

    friscv_apb_router_decode #(
        .ADDRW    (ADDRW),
        .NB_SLV   (NB_SLV),
        .IDXW     (IDXW),
        .SLV_ADDR (SLV_ADDR),
        .SLV_SIZE (SLV_SIZE)
    ) u_decode (
        .i_addr  (mst_addr),
        .o_hit   (w_hit),
        .o_index (w_idx)
    );

    // A request is only taken in IDLE once the re-arm cycle after a response has passed
    assign w_accept = (r_state == IDLE) && !r_rearm && mst_en;
    assign w_start  = w_accept && w_hit;
    assign w_derr   = w_accept && !w_hit;

    // Only the selected slave's ready and read data matter during an access
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NB_SLV; i++) begin
            if (r_sel == IDXW'(i)) begin
                w_sel_ready = slv_ready[i];
                w_sel_rdata = slv_rdata[i*XLEN +: XLEN];
            end
        end
    end

    if (TIMEOUT > 0) begin : g_tmo
        assign w_timeout = (r_timer == TMR_LAST);
    end else begin : g_no_tmo
        assign w_timeout = 1'b0;
    end

    // Slave ready takes priority over a timeout landing on the same cycle
    assign w_acc_done = (r_state == ACCESS) && (w_sel_ready || w_timeout);

    // Main FSM: request acceptance, access tracking, single-cycle response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_rearm     <= 1'b0;
            r_sel       <= '0;
            r_timer     <= '0;
            r_mst_ready <= 1'b0;
            r_mst_err   <= 1'b0;
            r_mst_rdata <= '0;
        end else if (srst) begin
            r_state     <= IDLE;
            r_rearm     <= 1'b0;
            r_sel       <= '0;
            r_timer     <= '0;
            r_mst_ready <= 1'b0;
            r_mst_err   <= 1'b0;
            r_mst_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rearm <= 1'b0;
                    if (w_start) begin
                        r_state <= ACCESS;
                        r_sel   <= w_idx;
                        r_timer <= '0;
                    end else if (w_derr) begin
                        r_state     <= RESP;
                        r_mst_ready <= 1'b1;
                        r_mst_err   <= 1'b1;
                        r_mst_rdata <= '0;
                    end
                end
                ACCESS: begin
                    if (w_sel_ready) begin
                        r_state     <= RESP;
                        r_mst_ready <= 1'b1;
                        r_mst_err   <= 1'b0;
                        r_mst_rdata <= w_sel_rdata;
                    end else if (w_timeout) begin
                        r_state     <= RESP;
                        r_mst_ready <= 1'b1;
                        r_mst_err   <= 1'b1;
                        r_mst_rdata <= '0;
                    end else if (r_timer != {TMRW{1'b1}}) begin
                        r_timer <= r_timer + TMRW'(1);
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rearm     <= 1'b1;
                    r_mst_ready <= 1'b0;
                    r_mst_err   <= 1'b0;
                    r_mst_rdata <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mst_ready = r_mst_ready;
    assign mst_err   = r_mst_err;
    assign mst_rdata = r_mst_rdata;

    for (genvar i = 0; i < NB_SLV; i++) begin : g_slv
        logic             r_en;
        logic             r_wr;
        logic [ADDRW-1:0] r_addr;
        logic [XLEN-1:0]  r_wdata;
        logic [STRBW-1:0] r_strb;

        // Per-slave request registers: loaded on acceptance, cleared when the access completes
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_en    <= 1'b0;
                r_wr    <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
                r_strb  <= '0;
            end else if (srst || w_acc_done) begin
                r_en    <= 1'b0;
                r_wr    <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
                r_strb  <= '0;
            end else if (w_start && (w_idx == IDXW'(i))) begin
                r_en    <= 1'b1;
                r_wr    <= mst_wr;
                r_addr  <= mst_addr;
                r_wdata <= mst_wdata;
                r_strb  <= mst_strb;
            end
        end

        assign slv_en[i]                   = r_en;
        assign slv_wr[i]                   = r_wr;
        assign slv_addr[i*ADDRW +: ADDRW]  = r_addr;
        assign slv_wdata[i*XLEN +: XLEN]   = r_wdata;
        assign slv_strb[i*STRBW +: STRBW]  = r_strb;
    end

endmodule

// File: tb/tb_friscv_apb_router.sv
// tb/tb_friscv_apb_router.sv - directed self-checking bench for friscv_apb_router
module tb_friscv_apb_router;

    localparam int ADDRW  = 16;
    localparam int XLEN   = 32;
    localparam int NB_SLV = 4;
    localparam logic [NB_SLV*ADDRW-1:0] SLV_ADDR = {16'h0800, 16'h0100, 16'h0500, 16'h0400};
    localparam logic [NB_SLV*ADDRW-1:0] SLV_SIZE = {16'h0100, 16'h0100, 16'h0100, 16'h0200};

    logic                      aclk;
    logic                      aresetn;
    logic                      srst;
    logic                      mst_en;
    logic                      mst_wr;
    logic [ADDRW-1:0]          mst_addr;
    logic [XLEN-1:0]           mst_wdata;
    logic [XLEN/8-1:0]         mst_strb;
    logic [XLEN-1:0]           mst_rdata;
    logic                      mst_ready;
    logic                      mst_err;
    logic [NB_SLV-1:0]         slv_en;
    logic [NB_SLV-1:0]         slv_wr;
    logic [NB_SLV*ADDRW-1:0]   slv_addr;
    logic [NB_SLV*XLEN-1:0]    slv_wdata;
    logic [NB_SLV*XLEN/8-1:0]  slv_strb;
    logic [NB_SLV*XLEN-1:0]    slv_rdata;
    logic [NB_SLV-1:0]         slv_ready;

    friscv_apb_router #(
        .ADDRW    (ADDRW),
        .XLEN     (XLEN),
        .NB_SLV   (NB_SLV),
        .SLV_ADDR (SLV_ADDR),
        .SLV_SIZE (SLV_SIZE),
        .TIMEOUT  (8)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .mst_en    (mst_en),
        .mst_wr    (mst_wr),
        .mst_addr  (mst_addr),
        .mst_wdata (mst_wdata),
        .mst_strb  (mst_strb),
        .mst_rdata (mst_rdata),
        .mst_ready (mst_ready),
        .mst_err   (mst_err),
        .slv_en    (slv_en),
        .slv_wr    (slv_wr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_strb  (slv_strb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Slave models: ready after wait_cfg cycles of enable, or never
    int         wait_cfg [NB_SLV];
    int         cnt      [NB_SLV];
    logic [3:0] never;

    assign slv_rdata = {32'hDDDD_3333, 32'h0000_1234, 32'hBBBB_1111, 32'hAAAA_0000};

    always @(posedge aclk) begin
        for (int i = 0; i < NB_SLV; i++) cnt[i] <= slv_en[i] ? cnt[i] + 1 : 0;
    end

    always_comb begin
        slv_ready = '0;
        for (int i = 0; i < NB_SLV; i++)
            slv_ready[i] = slv_en[i] && !never[i] && (cnt[i] >= wait_cfg[i]);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_access(
        input  logic [15:0]  a,
        input  logic         wr,
        input  logic [31:0]  wd,
        input  logic [3:0]   st,
        output int           lat,
        output logic [31:0]  rd,
        output logic         e,
        output logic [3:0]   mask,
        output int           en_cyc,
        output logic [127:0] cap_wd,
        output logic [63:0]  cap_ad,
        output logic [15:0]  cap_st,
        output logic [3:0]   cap_wr,
        output logic [3:0]   en_at_rdy
    );
        logic first;
        repeat (2) @(negedge aclk);
        mst_en = 1'b1; mst_wr = wr; mst_addr = a; mst_wdata = wd; mst_strb = st;
        lat = 0; en_cyc = 0; mask = '0; first = 1'b1;
        cap_wd = '0; cap_ad = '0; cap_st = '0; cap_wr = '0;
        do begin
            @(negedge aclk);
            lat++;
            mask |= slv_en;
            if (slv_en != '0) begin
                en_cyc++;
                if (first) begin
                    cap_wd = slv_wdata; cap_ad = slv_addr; cap_st = slv_strb; cap_wr = slv_wr;
                end
                first = 1'b0;
            end
        end while (!mst_ready && lat < 40);
        rd = mst_rdata; e = mst_err; en_at_rdy = slv_en;
        mst_en = 1'b0; mst_wr = 1'b0; mst_addr = '0; mst_wdata = '0; mst_strb = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int           lat, en_cyc, rdy_cnt, rise_cnt;
    logic [31:0]  rd;
    logic         e;
    logic [3:0]   mask, en_at_rdy, cap_wr, prev_en, idle_mask;
    logic [127:0] cap_wd;
    logic [63:0]  cap_ad;
    logic [15:0]  cap_st;

    initial begin
        aresetn = 1'b0; srst = 1'b0;
        mst_en = 1'b0; mst_wr = 1'b0; mst_addr = '0; mst_wdata = '0; mst_strb = '0;
        never = '0;
        for (int i = 0; i < NB_SLV; i++) wait_cfg[i] = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_ready", 64'(mst_ready), 64'd0);
        check("rst_err",   64'(mst_err),   64'd0);
        check("rst_rdata", 64'(mst_rdata), 64'd0);
        check("rst_slv_en", 64'(slv_en),   64'd0);

        // Write to slave 2, ready on third enable cycle
        wait_cfg[2] = 2;
        do_access(16'h0100, 1'b1, 32'h0000_CAFE, 4'hF, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("wr_latency", 64'(lat), 64'd4);
        check("wr_err",     64'(e),   64'd0);
        check("wr_en_mask", 64'(mask), 64'h4);
        check("wr_en_cyc",  64'(en_cyc), 64'd3);
        check("wr_wdata",   cap_wd[64 +: 64], 64'h0000_0000_0000_CAFE);
        check("wr_wdata_lo", cap_wd[0 +: 64], 64'h0);
        check("wr_addr",    cap_ad, 64'h0000_0100_0000_0000);
        check("wr_strb",    64'(cap_st), 64'h0F00);
        check("wr_wr",      64'(cap_wr), 64'h4);
        check("wr_en_done", 64'(en_at_rdy), 64'h0);

        // Zero-wait read at top byte of slave 2
        wait_cfg[2] = 0;
        do_access(16'h01FF, 1'b0, 32'h0, 4'h0, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("rd_latency", 64'(lat), 64'd2);
        check("rd_rdata",   64'(rd),  64'h1234);
        check("rd_err",     64'(e),   64'd0);
        check("rd_en_mask", 64'(mask), 64'h4);
        check("rd_wr",      64'(cap_wr), 64'h0);

        // Unmapped address just past slave 2
        do_access(16'h0200, 1'b0, 32'h0, 4'h0, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("unm_latency", 64'(lat), 64'd1);
        check("unm_err",     64'(e),   64'd1);
        check("unm_rdata",   64'(rd),  64'h0);
        check("unm_en_mask", 64'(mask), 64'h0);

        // Unmapped address just below slave 2
        do_access(16'h00FF, 1'b0, 32'h0, 4'h0, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("low_err",     64'(e),   64'd1);
        check("low_latency", 64'(lat), 64'd1);

        // Timeout on a slave that never answers
        never[3] = 1'b1;
        do_access(16'h0810, 1'b0, 32'h0, 4'h0, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("tmo_latency", 64'(lat), 64'd9);
        check("tmo_en_cyc",  64'(en_cyc), 64'd8);
        check("tmo_err",     64'(e),   64'd1);
        check("tmo_rdata",   64'(rd),  64'h0);
        check("tmo_en_done", 64'(en_at_rdy), 64'h0);

        // Overlap: slave 0 covers 0x400..0x5FF, slave 1 covers 0x500..0x5FF
        do_access(16'h0550, 1'b0, 32'h0, 4'h0, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("ovl_en_mask", 64'(mask), 64'h1);
        check("ovl_rdata",   64'(rd),  64'hAAAA_0000);
        check("ovl_latency", 64'(lat), 64'd2);

        // Back-to-back with mst_en held: one access every 4 cycles
        repeat (2) @(negedge aclk);
        mst_en = 1'b1; mst_wr = 1'b0; mst_addr = 16'h0100;
        rdy_cnt = 0; rise_cnt = 0; prev_en = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            if (mst_ready) rdy_cnt++;
            if (slv_en[2] && !prev_en[2]) rise_cnt++;
            prev_en = slv_en;
        end
        mst_en = 1'b0; mst_addr = '0;
        check("b2b_ready_cnt", 64'(rdy_cnt), 64'd3);
        check("b2b_en_rises",  64'(rise_cnt), 64'd3);
        idle_mask = '0;
        repeat (3) begin
            @(negedge aclk);
            idle_mask |= slv_en;
        end
        check("b2b_no_extra", 64'(idle_mask), 64'h0);

        // Synchronous reset mid-access
        repeat (2) @(negedge aclk);
        mst_en = 1'b1; mst_addr = 16'h0800;
        repeat (3) @(negedge aclk);
        check("srst_pre_en", 64'(slv_en), 64'h8);
        srst = 1'b1; mst_en = 1'b0; mst_addr = '0;
        @(negedge aclk);
        check("srst_en",    64'(slv_en),    64'h0);
        check("srst_ready", 64'(mst_ready), 64'd0);
        check("srst_addr",  slv_addr,       64'h0);
        srst = 1'b0;
        do_access(16'h01FF, 1'b0, 32'h0, 4'h0, lat, rd, e, mask, en_cyc, cap_wd, cap_ad, cap_st, cap_wr, en_at_rdy);
        check("post_srst_latency", 64'(lat), 64'd2);
        check("post_srst_rdata",   64'(rd),  64'h1234);

        // Asynchronous reset mid-access drops enable without a clock edge
        repeat (2) @(negedge aclk);
        mst_en = 1'b1; mst_addr = 16'h0800;
        repeat (2) @(negedge aclk);
        check("arst_pre_en", 64'(slv_en), 64'h8);
        #2 aresetn = 1'b0;
        #1;
        check("arst_en",    64'(slv_en),    64'h0);
        check("arst_ready", 64'(mst_ready), 64'd0);
        mst_en = 1'b0; mst_addr = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
